// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note events onto NVOICES envelope generators,
// allocating free voices first and stealing the least-recently-allocated voice otherwise.
module voice_allocator #(
   parameter int unsigned NVOICES = 4,
   parameter int unsigned KEYW    = 7
) (
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic                    ev_valid,
   output logic                    ev_ready,
   input  logic                    ev_on,
   input  logic [KEYW-1:0]         ev_key,
   input  logic [NVOICES-1:0]      voice_busy,
   output logic [NVOICES-1:0]      voice_note_on,
   output logic [NVOICES-1:0]      voice_note_off,
   output logic [NVOICES*KEYW-1:0] voice_key,
   output logic [NVOICES-1:0]      held,
   output logic                    steal
);

   localparam int unsigned IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_STEAL_OFF,
      S_STEAL_WAIT,
      S_ON_ISSUE,
      S_ARM,
      S_OFF_ISSUE
   } state_t;

   state_t                    state_q, state_d;
   logic                      cur_on_q, cur_on_d;
   logic [KEYW-1:0]           cur_key_q, cur_key_d;
   logic [IW-1:0]             tgt_q, tgt_d;
   logic [NVOICES-1:0]        held_q, held_d;
   logic [NVOICES*KEYW-1:0]   key_q, key_d;
   logic [IW-1:0]             age_q [NVOICES];
   logic [IW-1:0]             age_d [NVOICES];
   logic                      ready_q, ready_d;
   logic [NVOICES-1:0]        note_on_q, note_on_d;
   logic [NVOICES-1:0]        note_off_q, note_off_d;
   logic                      steal_q, steal_d;

   logic                      free_any, match_any;
   logic [IW-1:0]             free_idx, match_idx, old_idx, tgt_age;

   // Voice search: lowest free voice, lowest held voice matching cur_key, oldest voice.
   always_comb begin
      free_any  = 1'b0;
      match_any = 1'b0;
      free_idx  = '0;
      match_idx = '0;
      old_idx   = '0;
      tgt_age   = '0;
      for (int v = 0; v < int'(NVOICES); v++) begin
         if (!voice_busy[v] && !held_q[v] && !free_any) begin
            free_any = 1'b1;
            free_idx = IW'(v);
         end
         if (held_q[v] && (key_q[v*KEYW +: KEYW] == cur_key_q) && !match_any) begin
            match_any = 1'b1;
            match_idx = IW'(v);
         end
         if (age_q[v] == IW'(NVOICES - 1)) old_idx = IW'(v);
         if (tgt_q == IW'(v)) tgt_age = age_q[v];
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      cur_on_d  = cur_on_q;
      cur_key_d = cur_key_q;
      tgt_d     = tgt_q;
      held_d    = held_q;
      key_d     = key_q;
      age_d     = age_q;

      case (state_q)
         S_IDLE: begin
            if (ev_valid) begin
               cur_on_d  = ev_on;
               cur_key_d = ev_key;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            if (cur_on_q) begin
               if (match_any) begin
                  state_d = S_IDLE;
               end else if (free_any) begin
                  tgt_d   = free_idx;
                  state_d = S_ON_ISSUE;
               end else begin
                  tgt_d   = old_idx;
                  state_d = S_STEAL_OFF;
               end
            end else if (match_any) begin
               tgt_d   = match_idx;
               state_d = S_OFF_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_STEAL_OFF: begin
            for (int v = 0; v < int'(NVOICES); v++)
               if (tgt_q == IW'(v)) held_d[v] = 1'b0;
            state_d = S_STEAL_WAIT;
         end
         S_STEAL_WAIT: begin
            for (int v = 0; v < int'(NVOICES); v++)
               if (tgt_q == IW'(v) && !voice_busy[v]) state_d = S_ON_ISSUE;
         end
         S_ON_ISSUE: begin
            // Promote tgt to newest; everything younger than it ages by one.
            for (int v = 0; v < int'(NVOICES); v++) begin
               if (tgt_q == IW'(v)) begin
                  held_d[v]                = 1'b1;
                  key_d[v*KEYW +: KEYW]    = cur_key_q;
                  age_d[v]                 = '0;
               end else if (age_q[v] < tgt_age) begin
                  age_d[v] = age_q[v] + IW'(1);
               end
            end
            state_d = S_ARM;
         end
         S_ARM: begin
            for (int v = 0; v < int'(NVOICES); v++)
               if (tgt_q == IW'(v) && voice_busy[v]) state_d = S_IDLE;
         end
         S_OFF_ISSUE: begin
            for (int v = 0; v < int'(NVOICES); v++)
               if (tgt_q == IW'(v)) held_d[v] = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Moore outputs are registered from the next state so they line up with it.
      ready_d = (state_d == S_IDLE);
      steal_d = (state_d == S_STEAL_OFF);
      for (int v = 0; v < int'(NVOICES); v++) begin
         note_on_d[v]  = (state_d == S_ON_ISSUE) && (tgt_d == IW'(v));
         note_off_d[v] = (tgt_d == IW'(v)) &&
                         (((state_d == S_STEAL_OFF) && held_q[v]) || (state_d == S_OFF_ISSUE));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q    <= S_IDLE;
         cur_on_q   <= 1'b0;
         cur_key_q  <= '0;
         tgt_q      <= '0;
         held_q     <= '0;
         key_q      <= '0;
         for (int v = 0; v < int'(NVOICES); v++) age_q[v] <= IW'(v);
         ready_q    <= 1'b1;
         note_on_q  <= '0;
         note_off_q <= '0;
         steal_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_on_q   <= cur_on_d;
         cur_key_q  <= cur_key_d;
         tgt_q      <= tgt_d;
         held_q     <= held_d;
         key_q      <= key_d;
         age_q      <= age_d;
         ready_q    <= ready_d;
         note_on_q  <= note_on_d;
         note_off_q <= note_off_d;
         steal_q    <= steal_d;
      end
   end

   assign ev_ready       = ready_q;
   assign voice_note_on  = note_on_q;
   assign voice_note_off = note_off_q;
   assign voice_key      = key_q;
   assign held           = held_q;
   assign steal          = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with a simple envelope-generator busy model.
module tb_voice_allocator;

   localparam int unsigned NV  = 4;
   localparam int unsigned KW  = 7;
   localparam int          REL = 6;

   logic            clk = 1'b0;
   logic            rst_b = 1'b0;
   logic            ev_valid = 1'b0;
   logic            ev_ready;
   logic            ev_on = 1'b0;
   logic [KW-1:0]   ev_key = '0;
   logic [NV-1:0]   voice_busy;
   logic [NV-1:0]   voice_note_on;
   logic [NV-1:0]   voice_note_off;
   logic [NV*KW-1:0] voice_key;
   logic [NV-1:0]   held;
   logic            steal;

   logic [NV-1:0]   gen_busy;
   logic [NV-1:0]   busy_force = '0;
   int              rel_cnt [NV];
   int              n_tests = 0;
   int              n_fail  = 0;
   logic [NV*KW-1:0] vk;

   voice_allocator #(.NVOICES(NV), .KEYW(KW)) dut (
      .clk(clk), .rst_b(rst_b), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_on(ev_on), .ev_key(ev_key), .voice_busy(voice_busy),
      .voice_note_on(voice_note_on), .voice_note_off(voice_note_off),
      .voice_key(voice_key), .held(held), .steal(steal)
   );

   always #5 clk = ~clk;

   // Generator stand-in: busy rises after note_on, falls REL cycles after note_off.
   always @(posedge clk) begin
      if (!rst_b) begin
         gen_busy <= '0;
         for (int v = 0; v < int'(NV); v++) rel_cnt[v] <= 0;
      end else begin
         for (int v = 0; v < int'(NV); v++) begin
            if (voice_note_on[v]) begin
               gen_busy[v] <= 1'b1;
               rel_cnt[v]  <= 0;
            end else if (voice_note_off[v]) begin
               rel_cnt[v] <= REL;
            end else if (rel_cnt[v] != 0) begin
               rel_cnt[v] <= rel_cnt[v] - 1;
               if (rel_cnt[v] == 1) gen_busy[v] <= 1'b0;
            end
         end
      end
   end
   assign voice_busy = gen_busy | busy_force;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!ev_ready && n < 60) begin
         tick();
         n++;
      end
      chk(tag, 32'(ev_ready), 32'd1);
   endtask

   // Leaves the bench in cycle 1 (the accept edge is the end of cycle 0).
   task automatic send(input logic on, input logic [KW-1:0] key);
      wait_ready("ready_before_send");
      ev_valid = 1'b1;
      ev_on    = on;
      ev_key   = key;
      tick();
      ev_valid = 1'b0;
   endtask

   task automatic alloc(input string tag, input logic [KW-1:0] key, input logic [NV-1:0] exp_on);
      send(1'b1, key);
      chk({tag, "_c1_ready"}, 32'(ev_ready), 32'd0);
      tick();
      chk({tag, "_c2_note_on"}, 32'(voice_note_on), 32'(exp_on));
      tick();
      tick();
      chk({tag, "_c4_ready"}, 32'(ev_ready), 32'd1);
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      tick();
      tick();
      rst_b = 1'b1;
   endtask

   initial begin
      // Reset values
      rst_b = 1'b0;
      tick();
      tick();
      chk("rst_ready", 32'(ev_ready), 32'd1);
      chk("rst_held", 32'(held), 32'd0);
      chk("rst_key", 32'(voice_key), 32'd0);
      chk("rst_pulses", 32'({voice_note_on, voice_note_off, steal}), 32'd0);
      rst_b = 1'b1;
      tick();

      // Note-on 60 to idle bank, with per-cycle latency
      send(1'b1, 7'd60);
      chk("on60_c1_pulse", 32'(voice_note_on), 32'd0);
      tick();
      chk("on60_c2_pulse", 32'(voice_note_on), 32'b0001);
      chk("on60_c2_ready", 32'(ev_ready), 32'd0);
      tick();
      chk("on60_c3_pulse", 32'(voice_note_on), 32'd0);
      chk("on60_c3_held", 32'(held), 32'b0001);
      chk("on60_c3_key", 32'(voice_key), 32'd60);
      chk("on60_c3_ready", 32'(ev_ready), 32'd0);
      tick();
      chk("on60_c4_ready", 32'(ev_ready), 32'd1);

      // Note-off 60: pulse in cycle 2, ready in cycle 3
      send(1'b0, 7'd60);
      tick();
      chk("off60_c2_pulse", 32'(voice_note_off), 32'b0001);
      tick();
      chk("off60_c3_ready", 32'(ev_ready), 32'd1);
      chk("off60_c3_held", 32'(held), 32'd0);
      chk("off60_c3_pulse", 32'(voice_note_off), 32'd0);

      // Voice 0 still releasing, so 62 must land on voice 1
      alloc("on62", 7'd62, 4'b0010);
      vk = voice_key;
      chk("on62_key_v1", 32'(vk[13:7]), 32'd62);
      chk("on62_held", 32'(held), 32'b0010);

      // Duplicate note-on and stray note-off are dropped
      send(1'b1, 7'd62);
      tick();
      chk("dup62_c2_ready", 32'(ev_ready), 32'd1);
      chk("dup62_c2_pulses", 32'({voice_note_on, voice_note_off, steal}), 32'd0);
      chk("dup62_held", 32'(held), 32'b0010);
      send(1'b0, 7'd61);
      tick();
      chk("off61_c2_ready", 32'(ev_ready), 32'd1);
      chk("off61_c2_pulses", 32'({voice_note_on, voice_note_off, steal}), 32'd0);
      chk("off61_held", 32'(held), 32'b0010);

      // LRU: fresh bank, fill all four voices
      do_reset();
      alloc("lru60", 7'd60, 4'b0001);
      alloc("lru62", 7'd62, 4'b0010);
      alloc("lru64", 7'd64, 4'b0100);
      alloc("lru67", 7'd67, 4'b1000);
      chk("lru_held_full", 32'(held), 32'b1111);
      vk = voice_key;
      chk("lru_key_v3", 32'(vk[27:21]), 32'd67);

      // Release 62, wait for voice 1 to go idle, then 70 reuses it
      send(1'b0, 7'd62);
      tick();
      chk("off62_pulse", 32'(voice_note_off), 32'b0010);
      begin
         int n = 0;
         while (voice_busy[1] && n < 60) begin
            tick();
            n++;
         end
         chk("v1_idle", 32'(voice_busy[1]), 32'd0);
      end
      alloc("on70", 7'd70, 4'b0010);
      vk = voice_key;
      chk("on70_key_v1", 32'(vk[13:7]), 32'd70);

      // 72 steals voice 0 (age 3); note_on waits for its release to end
      send(1'b1, 7'd72);
      tick();
      chk("st72_c2_steal", 32'(steal), 32'd1);
      chk("st72_c2_off", 32'(voice_note_off), 32'b0001);
      tick();
      chk("st72_c3_steal", 32'(steal), 32'd0);
      chk("st72_c3_held", 32'(held), 32'b1110);
      chk("st72_c3_ready", 32'(ev_ready), 32'd0);
      repeat (6) tick();
      chk("st72_c9_on", 32'(voice_note_on), 32'd0);
      chk("st72_c9_busy0", 32'(voice_busy[0]), 32'd0);
      tick();
      chk("st72_c10_on", 32'(voice_note_on), 32'b0001);
      tick();
      vk = voice_key;
      chk("st72_key_v0", 32'(vk[6:0]), 32'd72);
      chk("st72_held", 32'(held), 32'b1111);
      wait_ready("st72_ready");

      // 80 steals voice 2 (now oldest); reset while in STEAL_WAIT
      send(1'b1, 7'd80);
      tick();
      chk("st80_c2_off", 32'(voice_note_off), 32'b0100);
      tick();
      chk("st80_c3_held", 32'(held), 32'b1011);
      tick();
      rst_b = 1'b0;
      tick();
      rst_b = 1'b1;
      chk("abort_ready", 32'(ev_ready), 32'd1);
      chk("abort_held", 32'(held), 32'd0);
      chk("abort_key", 32'(voice_key), 32'd0);
      chk("abort_pulses", 32'({voice_note_on, voice_note_off, steal}), 32'd0);
      busy_force = 4'b1111;
      repeat (3) begin
         tick();
         chk("abort_no_on", 32'(voice_note_on), 32'd0);
      end

      // All voices busy but unheld: reset ages make voice 3 the steal target
      send(1'b1, 7'd90);
      tick();
      chk("st90_c2_steal", 32'(steal), 32'd1);
      chk("st90_c2_off", 32'(voice_note_off), 32'd0);
      tick();
      busy_force = '0;
      tick();
      chk("st90_c4_on", 32'(voice_note_on), 32'b1000);
      tick();
      vk = voice_key;
      chk("st90_key_v3", 32'(vk[27:21]), 32'd90);
      chk("st90_held", 32'(held), 32'b1000);
      wait_ready("st90_ready");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler that sits between the note-event source and a bank of `NVOICES` envelope_generator instances. It accepts note-on/note-off events through a valid/ready handshake and assigns each note to a free voice. When every voice is in use, it steals the least-recently-allocated voice. It drives per-voice one-cycle `note_on`/`note_off` pulses, using each voice's `busy` output to decide when a voice is free.

## Interface
- `NVOICES`, default 4: number of envelope voices; legal range 2..8.
- `KEYW`, default 7: note key width.
- `clk`  in  1  sole clock; everything is sampled on the rising edge.
- `rst_b`  in  1  reset, synchronous, active-low.
- `ev_valid`  in  1  an event is offered.
- `ev_ready`  out  1  block can accept an event; equals (state == IDLE).
- `ev_on`  in  1  1 = note-on, 0 = note-off.
- `ev_key`  in  KEYW  note key of the event.
- `voice_busy`  in  NVOICES  the `busy` outputs of the envelope generators.
- `voice_note_on`  out  NVOICES  one-cycle note_on pulse per voice.
- `voice_note_off`  out  NVOICES  one-cycle note_off pulse per voice.
- `voice_key`  out  NVOICES*KEYW  key assigned to voice v, at bits [KEYW*v+KEYW-1 : KEYW*v].
- `held`  out  NVOICES  voice holds a key whose note-off has not yet arrived.
- `steal`  out  1  one-cycle pulse when a note-on takes an occupied voice.

## Operation
- Per-voice registers:
  - `held[v]`.
  - `voice_key[v]`.
  - `age[v]`: a distinct LRU rank 0..NVOICES-1, where 0 is newest.
- Voice v is free when `~voice_busy[v] & ~held[v]`.
- Event acceptance: an event is taken when `ev_valid & ev_ready`. `ev_on` and `ev_key` are latched into `cur_on` and `cur_key`.
- FSM states: IDLE, DECODE, STEAL_OFF, STEAL_WAIT, ON_ISSUE, ARM, OFF_ISSUE.
- IDLE: on accept → DECODE.
- DECODE with `cur_on=1`:
  - If some v has `held[v]` and `voice_key[v]==cur_key`: duplicate, → IDLE with no pulse.
  - Else if any voice is free: tgt = lowest-index free voice, → ON_ISSUE.
  - Else: tgt = voice with `age == NVOICES-1`, → STEAL_OFF.
- DECODE with `cur_on=0`:
  - If a held voice matches `cur_key`: tgt = that voice, → OFF_ISSUE.
  - Else: ignored, → IDLE.
- STEAL_OFF: `steal=1`. `voice_note_off[tgt]=1` only if `held[tgt]`. `held[tgt]` is cleared. → STEAL_WAIT.
- STEAL_WAIT: stay until `voice_busy[tgt]==0`, then → ON_ISSUE. There is no timeout; the wait lasts the full release time.
- ON_ISSUE:
  - `voice_note_on[tgt]=1`; `voice_key[tgt]<=cur_key`; `held[tgt]<=1`.
  - LRU update: every v with `age[v] < age[tgt]` increments, and `age[tgt] <= 0`.
  - → ARM.
- ARM: stay until `voice_busy[tgt]==1`, then → IDLE. This guarantees the generator has left IDLE before any later note_off can target it.
- OFF_ISSUE: `voice_note_off[tgt]=1`; `held[tgt]<=0`. → IDLE. The voice becomes free when its busy drops at the end of release.
- `voice_note_on`, `voice_note_off` and `steal` are Moore outputs decoded from state and `tgt`. At most one bit of each vector is high in any cycle.
- A voice whose note is released but still `busy` is neither free nor held. It can be chosen for stealing only through LRU rank.
- `age` ranks always remain a permutation of 0..NVOICES-1.

## Timing
- Reset (rst_b low at a clock edge) sets:
  - state = IDLE, so `ev_ready=1` from the next cycle.
  - `held=0`, `voice_key=0`, `age[v]=v`, `tgt=0`.
  - All pulses and `steal` at 0.
- Reset aborts any state, including STEAL_WAIT and ARM. No pulse is issued for the aborted event.
- Latency, with accept in cycle 0:
  - Note-on to a free voice: DECODE in cycle 1, note_on pulse in cycle 2, ARM in cycle 3 (generator busy is high by then), `ev_ready=1` in cycle 4.
  - Note-off: pulse in cycle 2, `ev_ready=1` in cycle 3.
  - Ignored or duplicate event: `ev_ready=1` in cycle 2.
  - Steal: `steal` and note_off pulse in cycle 2; STEAL_WAIT from cycle 3. Note_on comes one cycle after the cycle in which `voice_busy[tgt]` is sampled low.
- `ev_ready=0` in every state except IDLE. The source must hold `ev_valid`, `ev_on` and `ev_key` stable until accepted.
- ARM exits in one cycle when the generator behaves normally. If busy never rises, the FSM stays in ARM.

## Test plan
- Reset, then note-on key 60 with all voices idle → `voice_note_on[0]` pulses in cycle 2; `voice_key[0]=60`; `held=0001`; `ev_ready` high again in cycle 4.
- Note-on keys 60, 62, 64, 67, then note-on 72 while all are held:
  - `steal` and `voice_note_off[0]` pulse together.
  - After generator 0 finishes release (busy low), `voice_note_on[0]` pulses with `voice_key[0]=72`.
- Note-on 60, then note-off 60 → `voice_note_off[0]` pulses in cycle 2 after accept and `held[0]=0`; voice 0 is reused only after `voice_busy[0]` falls.
- Duplicate note-on 60 while 60 is held, and note-off 61 while 61 is not held → no pulses, no state change, `ev_ready` back in cycle 2.
- LRU check: allocate 60, 62, 64, 67; release 62; once voice 1 is idle, note-on 70 goes to voice 1. A further note-on 72 then steals voice 0, which has age 3.
- Assert `rst_b` low while in STEAL_WAIT → next cycle `ev_ready=1`, `held=0`, `age={3,2,1,0}` (v3..v0), no note_on pulse issued.
